// File: rtl/captura_operandos.sv
// rtl/captura_operandos.sv - operand-entry stage ahead of the 4-bit ALU
//
// One push button steps through the entry sequence A -> B+Cin -> opcode -> done.
// Each step latches the data switches. All outputs are held in flops.
//
// Optional feature macro: CAPTURA_CLR_EN adds the KEY_CLR_n clear button.
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   RST_n      in   asynchronous active-low reset
//   SW[3:0]    in   data switches (opcode taken from SW[2:0])
//   SW_CIN     in   carry/borrow-in switch
//   KEY_n      in   advance button, active low, bouncy, asynchronous
//   KEY_CLR_n  in   clear button, active low (only with CAPTURA_CLR_EN)
//   A_in[3:0]  out  held operand A
//   B_in[3:0]  out  held operand B
//   Cin        out  held carry/borrow-in
//   OP_sel[2:0] out held opcode
//   OPER_VALID out  all three fields captured since last restart
//   ESTADO[1:0] out current FSM state code

module captura_operandos_debounce #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic press_o
);
  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q   <= 1'b1;
      sync_q   <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      meta_q  <= key_n_i;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q == stable_q) begin
        // Any return to the accepted level restarts the count.
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
        stable_q <= sync_q;
        cnt_q    <= '0;
        // Only the accepted 1->0 edge (a press) produces a pulse.
        press_q  <= ~sync_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;
endmodule

module captura_operandos #(
  parameter int DEBOUNCE_CICLOS = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RST_n,
  input  logic [3:0] SW,
  input  logic       SW_CIN,
  input  logic       KEY_n,
`ifdef CAPTURA_CLR_EN
  input  logic       KEY_CLR_n,
`endif
  output logic [3:0] A_in,
  output logic [3:0] B_in,
  output logic       Cin,
  output logic [2:0] OP_sel,
  output logic       OPER_VALID,
  output logic [1:0] ESTADO
);
  localparam logic [1:0] S_A  = 2'b00;
  localparam logic [1:0] S_B  = 2'b01;
  localparam logic [1:0] S_OP = 2'b10;
  localparam logic [1:0] S_OK = 2'b11;

  logic       adv_press;
  logic       clr_press;

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic [2:0] op_q, op_d;
  logic       valid_q, valid_d;

  captura_operandos_debounce #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
    .CNT_W          (CNT_W)
  ) u_deb_adv (
    .clk_i  (CLOCK_50),
    .rst_n_i(RST_n),
    .key_n_i(KEY_n),
    .press_o(adv_press)
  );

`ifdef CAPTURA_CLR_EN
  captura_operandos_debounce #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS),
    .CNT_W          (CNT_W)
  ) u_deb_clr (
    .clk_i  (CLOCK_50),
    .rst_n_i(RST_n),
    .key_n_i(KEY_CLR_n),
    .press_o(clr_press)
  );
`else
  assign clr_press = 1'b0;
`endif

  // State and captured-field registers.
  always_ff @(posedge CLOCK_50 or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  end

  // Next state: clear dominates a simultaneous advance.
  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = S_A;
    end else if (adv_press) begin
      case (state_q)
        S_A:     state_d = S_B;
        S_B:     state_d = S_OP;
        S_OP:    state_d = S_OK;
        default: state_d = S_A;
      endcase
    end
  end

  // Captured fields: switches are sampled only on the press edge.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    op_d    = op_q;
    valid_d = valid_q;
    if (clr_press) begin
      a_d     = '0;
      b_d     = '0;
      cin_d   = 1'b0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (adv_press) begin
      case (state_q)
        S_A: a_d = SW;
        S_B: begin
          b_d   = SW;
          cin_d = SW_CIN;
        end
        S_OP: begin
          op_d    = SW[2:0];
          valid_d = 1'b1;
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign A_in       = a_q;
  assign B_in       = b_q;
  assign Cin        = cin_q;
  assign OP_sel     = op_q;
  assign OPER_VALID = valid_q;
  assign ESTADO     = state_q;
endmodule

// File: tb/tb_captura_operandos.sv
// tb/tb_captura_operandos.sv - self-checking bench for captura_operandos
module tb_captura_operandos;
  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       sw_cin;
  logic       key_n;
  logic [3:0] a_in, b_in;
  logic       cin;
  logic [2:0] op_sel;
  logic       oper_valid;
  logic [1:0] estado;

  always #5 clk = ~clk;

  captura_operandos #(
    .DEBOUNCE_CICLOS(DEB),
    .CNT_W          (3)
  ) dut (
    .CLOCK_50  (clk),
    .RST_n     (rst_n),
    .SW        (sw),
    .SW_CIN    (sw_cin),
    .KEY_n     (key_n),
    .A_in      (a_in),
    .B_in      (b_in),
    .Cin       (cin),
    .OP_sel    (op_sel),
    .OPER_VALID(oper_valid),
    .ESTADO    (estado)
  );

  typedef struct {
    logic [3:0] sw;
    logic       cin_sw;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [2:0] op;
    logic       v;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[8];
  vec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [1:0] last_st;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t e);
    check({tag, "_A_in"},       int'(a_in),       int'(e.a));
    check({tag, "_B_in"},       int'(b_in),       int'(e.b));
    check({tag, "_Cin"},        int'(cin),        int'(e.c));
    check({tag, "_OP_sel"},     int'(op_sel),     int'(e.op));
    check({tag, "_OPER_VALID"}, int'(oper_valid), int'(e.v));
    check({tag, "_ESTADO"},     int'(estado),     int'(e.st));
  endtask

  // Scoreboard consumer: every ESTADO change must match the next queued result.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (!rst_n) begin
      last_st = estado;
    end else if (estado !== last_st) begin
      last_st = estado;
      if (sb_q.size() == 0) begin
        check("unexpected_advance", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_outputs("sb", e);
      end
    end
  end

  task automatic press(input int hold, input vec_t e);
    int         n;
    bit         seen;
    logic [1:0] st0;
    sb_q.push_back(e);
    @(negedge clk);
    st0   = estado;
    key_n = 1'b0;
    n     = 0;
    seen  = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (!seen && estado !== st0) begin
        seen = 1'b1;
        n    = i + 1;
      end
    end
    check("press_seen", int'(seen), 1);
    if (seen) check("press_latency_ok", int'(n >= DEB + 2 && n <= DEB + 4), 1);
    @(negedge clk);
    key_n = 1'b1;
    repeat (12) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin : stim
    vec_t zero;
    zero = '{4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 3'h0, 1'b0, 2'b00};
    //           sw     cin    A      B      Cin   OP    V     ESTADO
    vecs[0] = '{4'h5, 1'b0, 4'h5, 4'h0, 1'b0, 3'h0, 1'b0, 2'b01};
    vecs[1] = '{4'h3, 1'b1, 4'h5, 4'h3, 1'b1, 3'h0, 1'b0, 2'b10};
    vecs[2] = '{4'h1, 1'b0, 4'h5, 4'h3, 1'b1, 3'h1, 1'b1, 2'b11};
    vecs[3] = '{4'hF, 1'b0, 4'h5, 4'h3, 1'b1, 3'h1, 1'b0, 2'b00};
    vecs[4] = '{4'h9, 1'b1, 4'h9, 4'h3, 1'b1, 3'h1, 1'b0, 2'b01};
    vecs[5] = '{4'hC, 1'b0, 4'h9, 4'hC, 1'b0, 3'h1, 1'b0, 2'b10};
    vecs[6] = '{4'hF, 1'b1, 4'h9, 4'hC, 1'b0, 3'h7, 1'b1, 2'b11};
    vecs[7] = '{4'h2, 1'b0, 4'h9, 4'hC, 1'b0, 3'h7, 1'b0, 2'b00};

    rst_n  = 1'b0;
    key_n  = 1'b1;
    sw     = 4'hA;
    sw_cin = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("reset", zero);
    rst_n = 1'b1;

    // Reset in the middle of a debounce count: nothing may fire afterwards.
    @(negedge clk);
    key_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("midreset", zero);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_outputs("postreset", zero);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sw     = vecs[i].sw;
      sw_cin = vecs[i].cin_sw;
      press((i == 4) ? 50 : 12, vecs[i]);
      sw     = 4'($urandom);
      sw_cin = 1'($urandom);
      if (i == 2) begin
        // Bouncy press shorter than the debounce window.
        @(negedge clk); key_n = 1'b0;
        repeat (2) @(negedge clk); key_n = 1'b1;
        @(negedge clk);             key_n = 1'b0;
        repeat (2) @(negedge clk); key_n = 1'b1;
        repeat (20) @(negedge clk);
        check_outputs("bounce", vecs[2]);
      end
      if (i == 3) begin
        // Switch activity without a press must not disturb the held values.
        repeat (10) begin
          @(negedge clk);
          sw     = 4'($urandom);
          sw_cin = 1'($urandom);
        end
        repeat (2) @(negedge clk);
        check_outputs("toggle", vecs[3]);
      end
      if (i == 4) begin
        repeat (20) @(negedge clk);
        check_outputs("hold", vecs[4]);
      end
    end

    repeat (10) @(negedge clk);
    check("sb_empty_end", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
